// File: rtl/regfile_ctrl.sv
// Command-driven initiator for the 8x16 register file.
// Sequences regfile read/write ports to perform MOVI, MOV, SWAP and READ.
module regfile_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3,
    parameter int unsigned IW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rm,
    input  logic [IW-1:0] cmd_imm,
    output logic [DW-1:0] rf_data_in,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [AW-1:0] rf_readnum,
    input  logic [DW-1:0] rf_data_out,
    output logic          done,
    output logic [DW-1:0] result
);

    typedef enum logic [1:0] {
        OpMovi = 2'b00,
        OpMov  = 2'b01,
        OpSwap = 2'b10,
        OpRead = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWrA,
        StWrB,
        StDone
    } state_e;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rm_q, rm_d;
    logic [IW-1:0] imm_q, imm_d;
    logic [DW-1:0] ta_q, ta_d;
    logic [DW-1:0] tb_q, tb_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] imm_sext;

    assign imm_sext = {{(DW - IW){imm_q[IW-1]}}, imm_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpMovi;
            rd_q     <= '0;
            rm_q     <= '0;
            imm_q    <= '0;
            ta_q     <= '0;
            tb_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rm_q     <= rm_d;
            imm_q    <= imm_d;
            ta_q     <= ta_d;
            tb_q     <= tb_d;
            result_q <= result_d;
        end
    end

    // Next state and operand capture; fields latch only on accept from idle.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rm_d     = rm_q;
        imm_d    = imm_q;
        ta_d     = ta_q;
        tb_d     = tb_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    rd_d    = cmd_rd;
                    rm_d    = cmd_rm;
                    imm_d   = cmd_imm;
                    state_d = (op_e'(cmd_op) == OpMovi) ? StWrA : StRdA;
                end
            end
            StRdA: begin
                if (op_q == OpRead) begin
                    result_d = rf_data_out;
                    state_d  = StDone;
                end else begin
                    ta_d    = rf_data_out;
                    state_d = (op_q == OpSwap) ? StRdB : StWrA;
                end
            end
            StRdB: begin
                tb_d    = rf_data_out;
                state_d = StWrA;
            end
            StWrA: begin
                state_d = (op_q == OpSwap) ? StWrB : StDone;
            end
            StWrB: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Regfile port drive: purely a function of state and latched fields.
    always_comb begin
        rf_data_in  = '0;
        rf_writenum = '0;
        rf_write    = 1'b0;
        rf_readnum  = '0;
        unique case (state_q)
            StRdA: begin
                rf_readnum = (op_q == OpRead) ? rd_q : rm_q;
            end
            StRdB: begin
                rf_readnum = rd_q;
            end
            StWrA: begin
                rf_write    = 1'b1;
                rf_writenum = rd_q;
                rf_data_in  = (op_q == OpMovi) ? imm_sext : ta_q;
            end
            StWrB: begin
                rf_write    = 1'b1;
                rf_writenum = rm_q;
                rf_data_in  = tb_q;
            end
            default: begin
            end
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign done      = (state_q == StDone);
    assign result    = result_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural regfile, reference model and
// write/result scoreboards checked per scenario.
module tb_regfile_ctrl;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rd = '0;
    logic [AW-1:0] cmd_rm = '0;
    logic [IW-1:0] cmd_imm = '0;
    logic [DW-1:0] rf_data_in;
    logic [AW-1:0] rf_writenum;
    logic          rf_write;
    logic [AW-1:0] rf_readnum;
    logic [DW-1:0] rf_data_out;
    logic          done;
    logic [DW-1:0] result;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0]    rf_mem [8];
    logic [DW-1:0]    ref_rf [8];
    logic [DW-1:0]    last_res = '0;
    logic [AW+DW-1:0] exp_wr [$];
    logic [AW+DW-1:0] wr_obs [$];
    logic [DW-1:0]    exp_res [$];
    logic [DW-1:0]    res_obs [$];

    regfile_ctrl #(.DW(DW), .AW(AW), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rm     (cmd_rm),
        .cmd_imm    (cmd_imm),
        .rf_data_in (rf_data_in),
        .rf_writenum(rf_writenum),
        .rf_write   (rf_write),
        .rf_readnum (rf_readnum),
        .rf_data_out(rf_data_out),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Behavioural 8x16 regfile: write on posedge, combinational read.
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    end
    assign rf_data_out = rf_mem[rf_readnum];

    always @(negedge clk) begin
        if (rf_write) wr_obs.push_back({rf_writenum, rf_data_in});
        if (done) res_obs.push_back(result);
    end

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rm,
                            input logic [7:0] imm, input bit upd);
        int n = 0;
        logic [DW-1:0] a, b, sx;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_wait got=%b want=1", cmd_ready);
        end
        sx = {{8{imm[7]}}, imm};
        if (upd) begin
            case (op)
                2'b00: begin
                    exp_wr.push_back({rd, sx});
                    ref_rf[rd] = sx;
                end
                2'b01: begin
                    exp_wr.push_back({rd, ref_rf[rm]});
                    ref_rf[rd] = ref_rf[rm];
                end
                2'b10: begin
                    a = ref_rf[rm];
                    b = ref_rf[rd];
                    exp_wr.push_back({rd, a});
                    exp_wr.push_back({rm, b});
                    ref_rf[rd] = a;
                    ref_rf[rm] = b;
                end
                default: last_res = ref_rf[rd];
            endcase
            exp_res.push_back(last_res);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rm    = rm;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_rd    = 3'($urandom_range(0, 7));
        cmd_rm    = 3'($urandom_range(0, 7));
        cmd_imm   = 8'($urandom_range(0, 255));
    endtask

    // cyc = posedges after the accept edge until done is seen; one_shot = done
    // dropped and ready returned on the following cycle.
    task automatic wait_done(output int cyc, output bit one_shot);
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        one_shot = !done && cmd_ready;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
        checks++;
        if ({rf_write, rf_writenum, rf_readnum, rf_data_in} !== '0) begin
            failures++;
            $display("FAIL rst_rf got=%b/%h/%h/%h want=0", rf_write, rf_writenum, rf_readnum, rf_data_in);
        end
        checks++;
        if (done !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL rst_done_result got=%b/%h want=0/0000", done, result);
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_movi_read();
        int cyc;
        bit os;
        logic [AW+DW-1:0] e, o;
        logic [DW-1:0] er, orr;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: send_cmd(2'b00, 3'd0, 3'd6, 8'h42, 1'b1);
                1: send_cmd(2'b11, 3'd0, 3'd6, 8'h00, 1'b1);
                2: send_cmd(2'b00, 3'd5, 3'd2, 8'h80, 1'b1);
                default: send_cmd(2'b11, 3'd5, 3'd1, 8'h00, 1'b1);
            endcase
            wait_done(cyc, os);
            checks++;
            if (cyc !== 1) begin failures++; $display("FAIL movi_read_lat[%0d] got=%0d want=1", i, cyc); end
            checks++;
            if (!os) begin failures++; $display("FAIL movi_read_pulse[%0d] got=0 want=1", i); end
        end
        checks++;
        if (result !== 16'hFF80) begin failures++; $display("FAIL sext_result got=%h want=ff80", result); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = 'x;
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL movi_write got=%h want=%h", o, e); end
        end
        while (exp_res.size() > 0) begin
            er = exp_res.pop_front();
            orr = 'x;
            if (res_obs.size() > 0) orr = res_obs.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL movi_result got=%h want=%h", orr, er); end
        end
    endtask

    task automatic test_swap();
        int cyc;
        bit os;
        logic [AW+DW-1:0] e, o;
        logic [DW-1:0] er, orr;
        logic [AW-1:0] ern, ewn;
        logic ew, ed;
        send_cmd(2'b00, 3'd1, 3'd0, 8'h23, 1'b1);
        wait_done(cyc, os);
        send_cmd(2'b00, 3'd2, 3'd0, 8'h7F, 1'b1);
        wait_done(cyc, os);
        send_cmd(2'b10, 3'd1, 3'd2, 8'h00, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ern = (c == 0) ? 3'd2 : (c == 1) ? 3'd1 : 3'd0;
            ew  = (c == 2 || c == 3);
            ewn = (c == 2) ? 3'd1 : (c == 3) ? 3'd2 : 3'd0;
            ed  = (c == 4);
            checks++;
            if ({rf_readnum, rf_write, rf_writenum, done} !== {ern, ew, ewn, ed}) begin
                failures++;
                $display("FAIL swap_cycle[%0d] got rn=%0d w=%b wn=%0d d=%b want rn=%0d w=%b wn=%0d d=%b",
                         c, rf_readnum, rf_write, rf_writenum, done, ern, ew, ewn, ed);
            end
        end
        send_cmd(2'b11, 3'd1, 3'd0, 8'h00, 1'b1);
        wait_done(cyc, os);
        checks++;
        if (result !== 16'h007F) begin failures++; $display("FAIL swap_r1 got=%h want=007f", result); end
        send_cmd(2'b11, 3'd2, 3'd0, 8'h00, 1'b1);
        wait_done(cyc, os);
        checks++;
        if (result !== 16'h0023) begin failures++; $display("FAIL swap_r2 got=%h want=0023", result); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = 'x;
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL swap_write got=%h want=%h", o, e); end
        end
        checks++;
        if (wr_obs.size() != 0) begin
            failures++;
            $display("FAIL swap_extra_writes got=%0d want=0", wr_obs.size());
            wr_obs.delete();
        end
        while (exp_res.size() > 0) begin
            er = exp_res.pop_front();
            orr = 'x;
            if (res_obs.size() > 0) orr = res_obs.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL swap_result got=%h want=%h", orr, er); end
        end
    endtask

    task automatic test_mov_busy();
        int cyc;
        bit os;
        logic [AW+DW-1:0] e, o;
        logic [DW-1:0] er, orr;
        send_cmd(2'b01, 3'd7, 3'd1, 8'h00, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mov_busy_ready[%0d] got=%b want=0", c, cmd_ready); end
            cmd_valid = (c != 2);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_rd    = 3'($urandom_range(0, 7));
            cmd_rm    = 3'($urandom_range(0, 7));
            cmd_imm   = 8'($urandom_range(0, 255));
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL mov_done got=%b want=1", done); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL mov_idle got ready=%b done=%b want 1/0", cmd_ready, done);
        end
        cmd_valid = 1'b0;
        send_cmd(2'b11, 3'd7, 3'd0, 8'h00, 1'b1);
        wait_done(cyc, os);
        checks++;
        if (result !== 16'h007F) begin failures++; $display("FAIL mov_r7 got=%h want=007f", result); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = 'x;
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL mov_write got=%h want=%h", o, e); end
        end
        checks++;
        if (wr_obs.size() != 0) begin
            failures++;
            $display("FAIL mov_extra_writes got=%0d want=0", wr_obs.size());
            wr_obs.delete();
        end
        while (exp_res.size() > 0) begin
            er = exp_res.pop_front();
            orr = 'x;
            if (res_obs.size() > 0) orr = res_obs.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL mov_result got=%h want=%h", orr, er); end
        end
    endtask

    task automatic test_swap_same();
        int cyc;
        bit os;
        logic [AW+DW-1:0] e, o;
        send_cmd(2'b00, 3'd3, 3'd0, 8'h12, 1'b1);
        wait_done(cyc, os);
        send_cmd(2'b10, 3'd3, 3'd3, 8'h00, 1'b1);
        wait_done(cyc, os);
        checks++;
        if (cyc !== 4) begin failures++; $display("FAIL swap_same_lat got=%0d want=4", cyc); end
        send_cmd(2'b11, 3'd3, 3'd0, 8'h00, 1'b1);
        wait_done(cyc, os);
        checks++;
        if (result !== 16'h0012) begin failures++; $display("FAIL swap_same_r3 got=%h want=0012", result); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = 'x;
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL swap_same_write got=%h want=%h", o, e); end
        end
        exp_res.delete();
        res_obs.delete();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit os;
        logic [DW-1:0] er, orr;
        send_cmd(2'b10, 3'd1, 3'd2, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rf_readnum !== 3'd1) begin failures++; $display("FAIL rdb_readnum got=%0d want=1", rf_readnum); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || result !== 16'h0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state got ready=%b result=%h done=%b want 1/0000/0", cmd_ready, result, done);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rf_write !== 1'b0) begin failures++; $display("FAIL midrst_write[%0d] got=%b want=0", c, rf_write); end
        end
        rst_n = 1'b1;
        last_res = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_obs.size() != 0) begin
            failures++;
            $display("FAIL midrst_writes got=%0d want=0", wr_obs.size());
            wr_obs.delete();
        end
        send_cmd(2'b11, 3'd1, 3'd0, 8'h00, 1'b1);
        wait_done(cyc, os);
        send_cmd(2'b11, 3'd2, 3'd0, 8'h00, 1'b1);
        wait_done(cyc, os);
        while (exp_res.size() > 0) begin
            er = exp_res.pop_front();
            orr = 'x;
            if (res_obs.size() > 0) orr = res_obs.pop_front();
            checks++;
            if (orr !== er) begin failures++; $display("FAIL midrst_result got=%h want=%h", orr, er); end
        end
        checks++;
        if (result !== 16'h0023) begin failures++; $display("FAIL midrst_r2 got=%h want=0023", result); end
    endtask

    initial begin
        test_reset();
        test_movi_read();
        test_swap();
        test_mov_busy();
        test_swap_same();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Command-driven initiator for the 8x16 register file: the master side of the regfile write/read port interface.
- Accepts one register-transfer command at a time over a valid/ready handshake: MOVI, MOV, SWAP or READ.
- Sequences the regfile's writenum/write/data_in and readnum/data_out ports over multiple cycles.
- Sits between the future instruction decoder and the existing regfile; every read and write of the regfile goes through it.

Parameters:
- DW, 16, data width; matches regfile data_in/data_out.
- AW, 3, register index width; 2^AW registers.
- IW, 8, immediate width; sign-extended to DW.

Ports:
- clk  input  1  rising-edge clock, shared with regfile
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 MOVI, 01 MOV, 10 SWAP, 11 READ
- cmd_rd  input  AW  destination / first register
- cmd_rm  input  AW  source / second register
- cmd_imm  input  IW  immediate for MOVI
- rf_data_in  output  DW  to regfile data_in
- rf_writenum  output  AW  to regfile writenum
- rf_write  output  1  to regfile write
- rf_readnum  output  AW  to regfile readnum
- rf_data_out  input  DW  from regfile data_out (combinational read)
- done  output  1  one-cycle pulse: command complete
- result  output  DW  value captured by the last READ

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; latched op/rd/rm/imm, ta, tb and result cleared to 0; done=0.
  - All rf_* outputs are 0 and rf_write is never 1 during reset.
  - cmd_ready=1 while in IDLE, including during reset.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, DONE. cmd_ready = (state==IDLE).
- Accept: a posedge with cmd_valid=1 in IDLE latches op, rd, rm and imm.
  - cmd_valid in any other state is ignored and nothing is latched.
- Transitions after accept:
  - MOVI: WR_A -> DONE
  - MOV: RD_A -> WR_A -> DONE
  - SWAP: RD_A -> RD_B -> WR_A -> WR_B -> DONE
  - READ: RD_A -> DONE
  - DONE -> IDLE always.
- Read states:
  - RD_A: rf_readnum = rm (rd for READ). At the posedge leaving RD_A, rf_data_out is captured into ta; for READ it is captured into result instead.
  - RD_B: rf_readnum = rd; rf_data_out captured into tb at exit.
- Write states:
  - WR_A: rf_write=1, rf_writenum=rd, rf_data_in = sext(imm) for MOVI, else ta.
  - WR_B: rf_write=1, rf_writenum=rm, rf_data_in=tb.
  - The regfile commits each write on the posedge ending that state.
- Idle values: outside WR states rf_write=0, rf_writenum=0, rf_data_in=0. Outside RD states rf_readnum=0.
- rf_* outputs are combinational from state and latched fields; they are stable for the whole cycle.
- done=1 exactly for the DONE cycle; all writes are already committed when done=1.
- result holds until the next READ completes.
- Cycles from accept edge to done=1: MOVI 1, MOV 2, SWAP 4, READ 1. Back-to-back throughput adds one IDLE cycle per command.
- Sign extension: bit IW-1 of imm is replicated into bits DW-1..IW.
- Boundary cases:
  - SWAP or MOV with rd==rm: full sequence runs; register value unchanged.
  - rst_n low mid-command: immediate return to IDLE; no further write is issued; a write already committed stays.
  - cmd fields changing after accept have no effect.

Test Plan:
- Bench instantiates regfile_ctrl driving a real regfile and checks rf_* ports cycle by cycle.
- MOVI rd=0 imm=0x42, then READ rd=0 -> done 1 cycle after each accept; result=0x0042.
- MOVI rd=5 imm=0x80, READ 5 -> result=0xFF80 (sign-extend).
- MOVI R1=0x23, MOVI R2=0x7F; SWAP rd=1 rm=2:
  - rf_write high exactly 2 cycles, writenum 1 then 2.
  - READ 1 -> 0x007F; READ 2 -> 0x0023.
- MOV rd=7 rm=1 while toggling cmd_valid with other fields during busy:
  - only one write occurs, R7=R1.
  - cmd_ready=0 for 3 cycles after accept.
- SWAP rd=3 rm=3 with R3=0x0012 -> R3 stays 0x0012; done after 4 cycles.
- Assert rst_n=0 in RD_B of a SWAP:
  - rf_write never rises; R1 and R2 are unchanged.
  - cmd_ready=1 immediately; result=0.
